// File: rtl/obi_reg_responder_if.sv
// Bus bundle between an OBI manager, the OBI-to-regbus responder and a regbus register file.
// The slave modport is the responder's view; master is the environment's view of the same wires.
interface obi_reg_responder_if #(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned IdWidth   = 3
);
   localparam int unsigned BeWidth = DataWidth / 8;

   // OBI subordinate side
   logic                 obi_req_i;
   logic                 obi_gnt_o;
   logic [AddrWidth-1:0] obi_addr_i;
   logic                 obi_we_i;
   logic [BeWidth-1:0]   obi_be_i;
   logic [DataWidth-1:0] obi_wdata_i;
   logic [IdWidth-1:0]   obi_aid_i;
   logic                 obi_rvalid_o;
   logic [DataWidth-1:0] obi_rdata_o;
   logic [IdWidth-1:0]   obi_rid_o;
   logic                 obi_err_o;

   // Regbus manager side
   logic                 reg_valid_o;
   logic [AddrWidth-1:0] reg_addr_o;
   logic                 reg_write_o;
   logic [DataWidth-1:0] reg_wdata_o;
   logic [BeWidth-1:0]   reg_wstrb_o;
   logic                 reg_ready_i;
   logic [DataWidth-1:0] reg_rdata_i;
   logic                 reg_error_i;

   modport slave (
      input  obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i, obi_aid_i,
      output obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_rid_o, obi_err_o,
      output reg_valid_o, reg_addr_o, reg_write_o, reg_wdata_o, reg_wstrb_o,
      input  reg_ready_i, reg_rdata_i, reg_error_i
   );

   modport master (
      output obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i, obi_aid_i,
      input  obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_rid_o, obi_err_o,
      input  reg_valid_o, reg_addr_o, reg_write_o, reg_wdata_o, reg_wstrb_o,
      output reg_ready_i, reg_rdata_i, reg_error_i
   );
endinterface

// File: rtl/obi_reg_responder.sv
// OBI subordinate that turns one transaction at a time into a single-beat regbus access.
// Optional regbus wait limit enabled by defining OBI_REG_TIMEOUT_EN.
module obi_reg_responder #(
   parameter int unsigned AddrWidth     = 32,
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned IdWidth       = 3,
   parameter int unsigned TimeoutCycles = 255
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   obi_reg_responder_if.slave bus
);
   localparam int unsigned BeWidth = DataWidth / 8;

   if (TimeoutCycles == 0) begin : gen_bad_timeout
      $error("TimeoutCycles must be at least 1");
   end

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   state_e               state_q, state_d;
   logic [AddrWidth-1:0] addr_q, addr_d;
   logic                 we_q, we_d;
   logic [BeWidth-1:0]   wstrb_q, wstrb_d;
   logic [DataWidth-1:0] wdata_q, wdata_d;
   logic [IdWidth-1:0]   aid_q, aid_d;
   logic                 valid_q, valid_d;
   logic                 rvalid_q, rvalid_d;
   logic [DataWidth-1:0] rdata_q, rdata_d;
   logic [IdWidth-1:0]   rid_q, rid_d;
   logic                 err_q, err_d;
   logic                 gnt;

`ifdef OBI_REG_TIMEOUT_EN
   localparam int unsigned CntWidth =
      ($clog2(TimeoutCycles + 1) > 8) ? $clog2(TimeoutCycles + 1) : 8;
   localparam logic [CntWidth-1:0] TimeoutCnt = CntWidth'(TimeoutCycles);
   localparam logic [DataWidth-1:0] TimeoutData = DataWidth'(32'hBADCAB1E);

   logic [CntWidth-1:0] cnt_q, cnt_d, cnt_inc;
   assign cnt_inc = cnt_q + 1'b1;
`endif

   // Grant only while no access is in flight; the RESP cycle retires the old response.
   assign gnt = rst_ni && bus.obi_req_i && (state_q != StAccess);

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      we_d     = we_q;
      wstrb_d  = wstrb_q;
      wdata_d  = wdata_q;
      aid_d    = aid_q;
      valid_d  = 1'b0;
      rvalid_d = 1'b0;
      rdata_d  = '0;
      rid_d    = '0;
      err_d    = 1'b0;
`ifdef OBI_REG_TIMEOUT_EN
      cnt_d    = cnt_q;
`endif

      unique case (state_q)
         StIdle, StResp: begin
            if (gnt) begin
               addr_d  = bus.obi_addr_i;
               we_d    = bus.obi_we_i;
               wstrb_d = bus.obi_we_i ? bus.obi_be_i : '0;
               wdata_d = bus.obi_wdata_i;
               aid_d   = bus.obi_aid_i;
               valid_d = 1'b1;
               state_d = StAccess;
`ifdef OBI_REG_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end else begin
               state_d = StIdle;
            end
         end

         StAccess: begin
            if (bus.reg_ready_i) begin
               rvalid_d = 1'b1;
               rdata_d  = we_q ? '0 : bus.reg_rdata_i;
               err_d    = bus.reg_error_i;
               rid_d    = aid_q;
               state_d  = StResp;
            end
`ifdef OBI_REG_TIMEOUT_EN
            else if (cnt_inc == TimeoutCnt) begin
               rvalid_d = 1'b1;
               rdata_d  = TimeoutData;
               err_d    = 1'b1;
               rid_d    = aid_q;
               state_d  = StResp;
            end else begin
               cnt_d   = cnt_inc;
               valid_d = 1'b1;
            end
`else
            else begin
               valid_d = 1'b1;
            end
`endif
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         we_q     <= 1'b0;
         wstrb_q  <= '0;
         wdata_q  <= '0;
         aid_q    <= '0;
         valid_q  <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rid_q    <= '0;
         err_q    <= 1'b0;
`ifdef OBI_REG_TIMEOUT_EN
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         wstrb_q  <= wstrb_d;
         wdata_q  <= wdata_d;
         aid_q    <= aid_d;
         valid_q  <= valid_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         rid_q    <= rid_d;
         err_q    <= err_d;
`ifdef OBI_REG_TIMEOUT_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   assign bus.obi_gnt_o    = gnt;
   assign bus.obi_rvalid_o = rvalid_q;
   // Response fields are loaded only on entry to RESP, so they read as zero elsewhere.
   assign bus.obi_rdata_o  = rdata_q;
   assign bus.obi_rid_o    = rid_q;
   assign bus.obi_err_o    = err_q;

   assign bus.reg_valid_o  = valid_q;
   assign bus.reg_addr_o   = addr_q;
   assign bus.reg_write_o  = we_q;
   assign bus.reg_wdata_o  = wdata_q;
   assign bus.reg_wstrb_o  = wstrb_q;
endmodule

// File: tb/tb_obi_reg_responder.sv
// Self-checking bench for obi_reg_responder: directed scenarios plus a randomized run
// against a register-file reference model kept at the OBI transaction level.
module tb_obi_reg_responder;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned IW = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] rf_mem  [16];
   logic [31:0] ref_mem [16];

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      logic [2:0]  rid;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   always #5 clk = ~clk;

   obi_reg_responder_if #(.AddrWidth(AW), .DataWidth(DW), .IdWidth(IW)) bus ();

   obi_reg_responder #(
      .AddrWidth    (AW),
      .DataWidth    (DW),
      .IdWidth      (IW),
      .TimeoutCycles(4)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus.slave)
   );

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      bus.obi_req_i   = 1'b0;
      bus.obi_addr_i  = '0;
      bus.obi_we_i    = 1'b0;
      bus.obi_be_i    = '0;
      bus.obi_wdata_i = '0;
      bus.obi_aid_i   = '0;
      bus.reg_ready_i = 1'b0;
      bus.reg_rdata_i = '0;
      bus.reg_error_i = 1'b0;
   endtask

   task automatic drive_req(input logic [31:0] addr, input logic we, input logic [3:0] be,
                            input logic [31:0] wdata, input logic [2:0] aid);
      bus.obi_req_i   = 1'b1;
      bus.obi_addr_i  = addr;
      bus.obi_we_i    = we;
      bus.obi_be_i    = be;
      bus.obi_wdata_i = wdata;
      bus.obi_aid_i   = aid;
   endtask

   function automatic logic [107:0] all_outs();
      return {bus.obi_gnt_o, bus.obi_rvalid_o, bus.obi_rdata_o, bus.obi_rid_o, bus.obi_err_o,
              bus.reg_valid_o, bus.reg_addr_o, bus.reg_write_o, bus.reg_wdata_o,
              bus.reg_wstrb_o};
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
      return r;
   endfunction

   task automatic test_reset();
      logic [107:0] o;
      rst_n = 1'b0;
      drive_idle();
      bus.obi_req_i = 1'b1;
      @(negedge clk);
      o = all_outs();
      checks++;
      if (o !== '0) begin
         errors++;
         $display("FAIL reset_outputs got %h want 0", o);
      end
      bus.obi_req_i = 1'b0;
      next_cycle();
      rst_n = 1'b1;
      @(negedge clk);
      o = all_outs();
      checks++;
      if (o !== '0) begin
         errors++;
         $display("FAIL idle_after_reset got %h want 0", o);
      end
   endtask

   task automatic test_write();
      next_cycle();
      drive_req(32'h0300_5004, 1'b1, 4'b0011, 32'hDEADBEEF, 3'd5);
      @(negedge clk);
      checks++;
      if (bus.obi_gnt_o !== 1'b1) begin
         errors++;
         $display("FAIL write_gnt got %b want 1", bus.obi_gnt_o);
      end
      next_cycle();
      bus.obi_req_i   = 1'b0;
      bus.reg_ready_i = 1'b1;
      bus.reg_rdata_i = 32'hFFFF_FFFF;
      @(negedge clk);
      checks++;
      if ({bus.reg_valid_o, bus.reg_write_o, bus.reg_wstrb_o, bus.reg_wdata_o, bus.reg_addr_o,
           bus.obi_rvalid_o} !== {1'b1, 1'b1, 4'b0011, 32'hDEADBEEF, 32'h0300_5004, 1'b0}) begin
         errors++;
         $display("FAIL write_regbus got v=%b w=%b s=%b d=%h a=%h rv=%b want 1 1 0011 deadbeef 03005004 0",
                  bus.reg_valid_o, bus.reg_write_o, bus.reg_wstrb_o, bus.reg_wdata_o,
                  bus.reg_addr_o, bus.obi_rvalid_o);
      end
      next_cycle();
      bus.reg_ready_i = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.obi_rvalid_o, bus.obi_rid_o, bus.obi_err_o, bus.obi_rdata_o, bus.reg_valid_o} !==
          {1'b1, 3'd5, 1'b0, 32'h0, 1'b0}) begin
         errors++;
         $display("FAIL write_resp got rv=%b rid=%0d err=%b rdata=%h v=%b want 1 5 0 0 0",
                  bus.obi_rvalid_o, bus.obi_rid_o, bus.obi_err_o, bus.obi_rdata_o,
                  bus.reg_valid_o);
      end
      next_cycle();
      @(negedge clk);
      checks++;
      if ({bus.obi_rvalid_o, bus.obi_rid_o} !== 4'b0) begin
         errors++;
         $display("FAIL write_resp_once got rv=%b rid=%0d want 0 0", bus.obi_rvalid_o,
                  bus.obi_rid_o);
      end
   endtask

   task automatic test_read_wait();
      int nv = 0;
      int nr = 0;
      next_cycle();
      drive_req(32'h0300_0000, 1'b0, 4'hF, 32'h0, 3'd2);
      @(negedge clk);
      checks++;
      if (bus.obi_gnt_o !== 1'b1) begin
         errors++;
         $display("FAIL read_gnt got %b want 1", bus.obi_gnt_o);
      end
      for (int c = 0; c < 8; c++) begin
         next_cycle();
         bus.obi_req_i   = 1'b0;
         bus.reg_ready_i = (c == 3);
         bus.reg_rdata_i = 32'h1234_5678;
         @(negedge clk);
         if (bus.reg_valid_o) begin
            nv++;
            checks++;
            if ({bus.reg_addr_o, bus.reg_wstrb_o, bus.reg_write_o} !==
                {32'h0300_0000, 4'b0, 1'b0}) begin
               errors++;
               $display("FAIL read_hold cycle %0d got a=%h s=%b w=%b want 03000000 0000 0", c,
                        bus.reg_addr_o, bus.reg_wstrb_o, bus.reg_write_o);
            end
         end
         if (bus.obi_rvalid_o) nr++;
         if (c == 4) begin
            checks++;
            if ({bus.obi_rvalid_o, bus.obi_rdata_o, bus.obi_rid_o, bus.obi_err_o} !==
                {1'b1, 32'h1234_5678, 3'd2, 1'b0}) begin
               errors++;
               $display("FAIL read_resp got rv=%b rdata=%h rid=%0d err=%b want 1 12345678 2 0",
                        bus.obi_rvalid_o, bus.obi_rdata_o, bus.obi_rid_o, bus.obi_err_o);
            end
         end
      end
      bus.reg_ready_i = 1'b0;
      checks++;
      if (nv != 4 || nr != 1) begin
         errors++;
         $display("FAIL read_counts got valid=%0d rvalid=%0d want 4 1", nv, nr);
      end
   endtask

   task automatic test_back_to_back();
      logic        eg, er;
      logic [2:0]  erid;
      logic [31:0] erd;
      for (int c = 0; c < 6; c++) begin
         next_cycle();
         drive_req(32'h0300_0010, 1'b0, 4'hF, 32'h0, (c == 0) ? 3'd1 : 3'd3);
         bus.obi_req_i   = (c <= 2);
         bus.reg_ready_i = 1'b1;
         bus.reg_rdata_i = 32'h1111_0000 + c;
         eg   = (c == 0 || c == 2);
         er   = (c == 2 || c == 4);
         erid = (c == 2) ? 3'd1 : (c == 4) ? 3'd3 : 3'd0;
         erd  = (c == 2) ? 32'h1111_0001 : (c == 4) ? 32'h1111_0003 : 32'h0;
         @(negedge clk);
         checks++;
         if ({bus.obi_gnt_o, bus.obi_rvalid_o, bus.obi_rid_o, bus.obi_rdata_o} !==
             {eg, er, erid, erd}) begin
            errors++;
            $display("FAIL b2b cycle %0d got g=%b rv=%b rid=%0d rd=%h want %b %b %0d %h", c,
                     bus.obi_gnt_o, bus.obi_rvalid_o, bus.obi_rid_o, bus.obi_rdata_o,
                     eg, er, erid, erd);
         end
      end
      bus.obi_req_i   = 1'b0;
      bus.reg_ready_i = 1'b0;
   endtask

   task automatic test_error();
      next_cycle();
      drive_req(32'h0300_0020, 1'b0, 4'hF, 32'h0, 3'd6);
      @(negedge clk);
      checks++;
      if (bus.obi_gnt_o !== 1'b1) begin
         errors++;
         $display("FAIL error_gnt got %b want 1", bus.obi_gnt_o);
      end
      next_cycle();
      bus.obi_req_i   = 1'b0;
      bus.reg_ready_i = 1'b1;
      bus.reg_error_i = 1'b1;
      bus.reg_rdata_i = 32'hCAFE_F00D;
      @(negedge clk);
      next_cycle();
      bus.reg_ready_i = 1'b0;
      bus.reg_error_i = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.obi_rvalid_o, bus.obi_err_o, bus.obi_rid_o, bus.obi_rdata_o} !==
          {1'b1, 1'b1, 3'd6, 32'hCAFE_F00D}) begin
         errors++;
         $display("FAIL error_resp got rv=%b err=%b rid=%0d rd=%h want 1 1 6 cafef00d",
                  bus.obi_rvalid_o, bus.obi_err_o, bus.obi_rid_o, bus.obi_rdata_o);
      end
      next_cycle();
      @(negedge clk);
      checks++;
      if ({bus.obi_rvalid_o, bus.obi_err_o} !== 2'b00) begin
         errors++;
         $display("FAIL error_clear got rv=%b err=%b want 0 0", bus.obi_rvalid_o,
                  bus.obi_err_o);
      end
   endtask

   task automatic test_reset_mid();
      logic [107:0] o;
      next_cycle();
      drive_req(32'h0300_0008, 1'b1, 4'hF, 32'h55AA_55AA, 3'd4);
      @(negedge clk);
      next_cycle();
      bus.obi_req_i = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.reg_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_valid got %b want 1", bus.reg_valid_o);
      end
      next_cycle();
      rst_n = 1'b0;
      #1;
      o = all_outs();
      checks++;
      if (o !== '0) begin
         errors++;
         $display("FAIL rstmid_outputs got %h want 0", o);
      end
      next_cycle();
      rst_n = 1'b1;
      bus.reg_ready_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) next_cycle();
         @(negedge clk);
         checks++;
         if ({bus.obi_rvalid_o, bus.reg_valid_o} !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_no_resp cycle %0d got rv=%b v=%b want 0 0", k,
                     bus.obi_rvalid_o, bus.reg_valid_o);
         end
      end
      next_cycle();
      bus.reg_ready_i = 1'b0;
      drive_req(32'h0300_0004, 1'b0, 4'hF, 32'h0, 3'd7);
      @(negedge clk);
      next_cycle();
      bus.obi_req_i   = 1'b0;
      bus.reg_ready_i = 1'b1;
      bus.reg_rdata_i = 32'h0BAD_F00D;
      @(negedge clk);
      next_cycle();
      bus.reg_ready_i = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.obi_rvalid_o, bus.obi_rid_o, bus.obi_rdata_o, bus.obi_err_o} !==
          {1'b1, 3'd7, 32'h0BAD_F00D, 1'b0}) begin
         errors++;
         $display("FAIL rstmid_recover got rv=%b rid=%0d rd=%h err=%b want 1 7 0badf00d 0",
                  bus.obi_rvalid_o, bus.obi_rid_o, bus.obi_rdata_o, bus.obi_err_o);
      end
   endtask

`ifdef OBI_REG_TIMEOUT_EN
   task automatic test_timeout();
      int nv = 0;
      int nr = 0;
      next_cycle();
      drive_req(32'h0300_000C, 1'b0, 4'hF, 32'h0, 3'd3);
      @(negedge clk);
      for (int c = 0; c < 10; c++) begin
         next_cycle();
         bus.obi_req_i   = 1'b0;
         bus.reg_ready_i = (c >= 6);
         bus.reg_rdata_i = 32'h7777_7777;
         @(negedge clk);
         if (bus.reg_valid_o) nv++;
         if (bus.obi_rvalid_o) nr++;
         if (c == 4) begin
            checks++;
            if ({bus.obi_rvalid_o, bus.obi_err_o, bus.obi_rid_o, bus.obi_rdata_o} !==
                {1'b1, 1'b1, 3'd3, 32'hBADC_AB1E}) begin
               errors++;
               $display("FAIL timeout_resp got rv=%b err=%b rid=%0d rd=%h want 1 1 3 badcab1e",
                        bus.obi_rvalid_o, bus.obi_err_o, bus.obi_rid_o, bus.obi_rdata_o);
            end
         end
      end
      bus.reg_ready_i = 1'b0;
      checks++;
      if (nv != 4 || nr != 1) begin
         errors++;
         $display("FAIL timeout_counts got valid=%0d rvalid=%0d want 4 1", nv, nr);
      end
   endtask
`endif

   task automatic test_random();
      exp_t       q[$];
      exp_t       e;
      exp_t       f;
      logic       pending = 1'b0;
      int         waitc = 0;
      int         n_grant = 0;
      int         n_retire = 0;
      logic [3:0] idx;
      for (int i = 0; i < 16; i++) begin
         rf_mem[i]  = $urandom;
         ref_mem[i] = rf_mem[i];
      end
      for (int cyc = 0; cyc < 600; cyc++) begin
         next_cycle();
         if (!pending) begin
            if (cyc < 560 && $urandom_range(0, 99) < 60) begin
               pending = 1'b1;
               idx = 4'($urandom_range(0, 15));
               drive_req(32'h0300_0000 | {26'd0, idx, 2'b00}, 1'($urandom_range(0, 1)),
                         4'($urandom), $urandom, 3'($urandom));
            end else begin
               bus.obi_req_i = 1'b0;
            end
         end
         if (bus.reg_valid_o) begin
            bus.reg_ready_i = (waitc >= 2) || ($urandom_range(0, 1) == 1);
            bus.reg_rdata_i = rf_mem[bus.reg_addr_o[5:2]];
            bus.reg_error_i = (bus.reg_addr_o[5:2] == 4'hF);
         end else begin
            bus.reg_ready_i = ($urandom_range(0, 3) == 0);
            bus.reg_rdata_i = $urandom;
            bus.reg_error_i = 1'b0;
         end
         @(negedge clk);
         if (bus.obi_rvalid_o) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL rand_resp_unexpected cycle %0d rid=%0d", cyc, bus.obi_rid_o);
            end else begin
               f = q.pop_front();
               n_retire++;
               if ({bus.obi_rid_o, bus.obi_rdata_o, bus.obi_err_o} !==
                   {f.rid, f.rdata, f.err}) begin
                  errors++;
                  $display("FAIL rand_resp cycle %0d got rid=%0d rd=%h err=%b want %0d %h %b",
                           cyc, bus.obi_rid_o, bus.obi_rdata_o, bus.obi_err_o,
                           f.rid, f.rdata, f.err);
               end
            end
         end
         if (bus.reg_valid_o && bus.reg_ready_i) begin
            waitc = 0;
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL rand_access_unexpected cycle %0d addr=%h", cyc, bus.reg_addr_o);
            end else if ({bus.reg_addr_o, bus.reg_write_o, bus.reg_wstrb_o, bus.reg_wdata_o} !==
                         {q[0].addr, q[0].we, q[0].wstrb, q[0].wdata}) begin
               errors++;
               $display("FAIL rand_access cycle %0d got a=%h w=%b s=%b d=%h want %h %b %b %h",
                        cyc, bus.reg_addr_o, bus.reg_write_o, bus.reg_wstrb_o, bus.reg_wdata_o,
                        q[0].addr, q[0].we, q[0].wstrb, q[0].wdata);
            end
            if (bus.reg_write_o && !bus.reg_error_i)
               rf_mem[bus.reg_addr_o[5:2]] = merge(rf_mem[bus.reg_addr_o[5:2]],
                                                   bus.reg_wdata_o, bus.reg_wstrb_o);
         end else if (bus.reg_valid_o) begin
            waitc++;
         end
         if (bus.obi_req_i && bus.obi_gnt_o) begin
            idx     = bus.obi_addr_i[5:2];
            e.addr  = bus.obi_addr_i;
            e.we    = bus.obi_we_i;
            e.wstrb = bus.obi_we_i ? bus.obi_be_i : 4'b0;
            e.wdata = bus.obi_wdata_i;
            e.rid   = bus.obi_aid_i;
            e.err   = (idx == 4'hF);
            e.rdata = bus.obi_we_i ? 32'h0 : ref_mem[idx];
            if (bus.obi_we_i && !e.err) ref_mem[idx] = merge(ref_mem[idx], bus.obi_wdata_i,
                                                             bus.obi_be_i);
            q.push_back(e);
            n_grant++;
            pending = 1'b0;
         end
      end
      bus.obi_req_i   = 1'b0;
      bus.reg_ready_i = 1'b0;
      checks++;
      if (q.size() != 0 || pending) begin
         errors++;
         $display("FAIL rand_drain got outstanding=%0d pending=%b want 0 0", q.size(), pending);
      end
      checks++;
      if (n_retire != n_grant || n_retire < 50) begin
         errors++;
         $display("FAIL rand_throughput got retired=%0d granted=%0d want equal and >=50",
                  n_retire, n_grant);
      end
   endtask

   initial begin
      drive_idle();
      test_reset();
      test_write();
      test_read_wait();
      test_back_to_back();
      test_error();
      test_reset_mid();
`ifdef OBI_REG_TIMEOUT_EN
      test_timeout();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/obi_reg_responder.md
Name: obi_reg_responder

Overview:
- OBI subordinate (responder) that terminates one crossbar/peripheral-demux output and drives a register-interface (regbus) manager port toward a register file.
- Used between the peripheral demux and regbus peripherals (SoC control, GPIO, timer).
- Accepts one OBI transaction at a time, converts it to a regbus access, and returns the OBI response with the originating ID.
- OBI config on the subordinate side: 32-bit address, 32-bit data, 3-bit ID, no rready, full byte enables, no integrity.

Parameters:
- AddrWidth, 32, address width on both the OBI and regbus sides.
- DataWidth, 32, data width; byte-enable width is DataWidth/8.
- IdWidth, 3, OBI aid/rid width (1 + idx_width of 4 managers).
- TimeoutCycles, 255, regbus wait limit; used only when OBI_REG_TIMEOUT_EN is defined; minimum 1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- obi_req_i  in  1  OBI request
- obi_gnt_o  out  1  OBI grant
- obi_addr_i  in  AddrWidth  OBI address
- obi_we_i  in  1  OBI write enable
- obi_be_i  in  DataWidth/8  OBI byte enables
- obi_wdata_i  in  DataWidth  OBI write data
- obi_aid_i  in  IdWidth  OBI request ID
- obi_rvalid_o  out  1  OBI response valid
- obi_rdata_o  out  DataWidth  OBI read data
- obi_rid_o  out  IdWidth  OBI response ID
- obi_err_o  out  1  OBI error
- reg_valid_o  out  1  regbus valid
- reg_addr_o  out  AddrWidth  regbus address
- reg_write_o  out  1  regbus write
- reg_wdata_o  out  DataWidth  regbus write data
- reg_wstrb_o  out  DataWidth/8  regbus write strobes
- reg_ready_i  in  1  regbus ready
- reg_rdata_i  in  DataWidth  regbus read data
- reg_error_i  in  1  regbus error

Behaviour:
- Reset (async, rst_ni=0): state=IDLE; all outputs 0; any in-flight transaction is dropped and no response is issued for it.
- States and transitions:
  - IDLE: obi_gnt_o = obi_req_i (combinational). On req&&gnt, capture addr/we/be/wdata/aid into registers -> ACCESS.
  - ACCESS: reg_valid_o=1; reg_addr_o, reg_write_o, reg_wdata_o, reg_wstrb_o come from the captured registers and are held stable until ready. reg_wstrb_o = captured be when write, else 0. obi_gnt_o=0. On reg_ready_i=1: capture rdata (0 for writes) and error -> RESP.
  - RESP: obi_rvalid_o=1 for exactly one cycle; obi_rid_o=captured aid; obi_rdata_o and obi_err_o from captured values. obi_gnt_o = obi_req_i here as well. If req && gnt, capture the new request -> ACCESS; else -> IDLE.
- Latency and throughput:
  - gnt in cycle 0; reg_valid in cycle 1; with ready in cycle 1, rvalid in cycle 2.
  - rvalid is never in the same cycle as its own gnt.
  - Sustained throughput: 1 transaction per 2 cycles.
- At most one outstanding transaction. A grant in RESP is legal because that cycle retires the previous response.
- Outside RESP, obi_rdata_o, obi_rid_o and obi_err_o are 0.
- The address is forwarded unmodified; there is no alignment check.
- reg_valid_o is deasserted in the cycle after ready (single-beat regbus access).
- A regbus error sets obi_err_o=1. Read data on error is passed through as returned.

Optional Feature:
- Macro: OBI_REG_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter clears on entry to ACCESS and increments each cycle while reg_ready_i=0.
  - When the count reaches TimeoutCycles, reg_valid_o drops and the block goes to RESP with err=1 and rdata=32'hBADCAB1E.
  - A late reg_ready_i is ignored.
- Undefined: no counter is built; ACCESS waits indefinitely for reg_ready_i.

Test Plan:
- Write: req, addr=0x0300_5004, we=1, be=4'b0011, wdata=0xDEADBEEF, aid=5 -> gnt in cycle 0. In cycle 1: reg_valid=1, write=1, wstrb=0011, wdata=0xDEADBEEF. ready in cycle 1 -> rvalid in cycle 2 with rid=5, err=0, rdata=0.
- Read with wait: read of addr=0x0300_0000, aid=2, ready delayed 3 cycles, rdata=0x1234_5678 -> reg_valid held 4 cycles with stable addr and wstrb=0; rvalid once with rdata=0x12345678, rid=2.
- Back-to-back: req held high with aid 1 then aid 3, ready always 1 -> gnt in cycles 0 and 2, rvalid in cycles 2 and 4, rids 1 then 3.
- Error: reg_error_i=1 with ready -> err=1 on rvalid, rid matches the request.
- Reset mid-ACCESS: rst_ni low for 1 cycle while reg_valid=1 -> all outputs 0 at once; no rvalid follows; the next request works normally.
- Timeout (OBI_REG_TIMEOUT_EN, TimeoutCycles=4): ready held at 0 -> rvalid with err=1 and rdata=0xBADCAB1E; a ready arriving afterwards causes no second rvalid.
